// File: rtl/run_detect_if.sv
// Sample/threshold bus for run_detect_ctrl. The det_cnt member and its modport
// entries exist only when RUN_DETECT_COUNT_EN is defined.
interface run_detect_if #(
   parameter int N_W = 4
);
   logic           en;
   logic           w;
   logic           n_load;
   logic [N_W-1:0] n_in;
   logic [2:0]     state;
   logic [N_W-1:0] rl;
   logic           z;
`ifdef RUN_DETECT_COUNT_EN
   logic [7:0]     det_cnt;

   modport master (output en, w, n_load, n_in, input state, rl, z, det_cnt);
   modport slave  (input en, w, n_load, n_in, output state, rl, z, det_cnt);
`else
   modport master (output en, w, n_load, n_in, input state, rl, z);
   modport slave  (input en, w, n_load, n_in, output state, rl, z);
`endif
endinterface

// File: rtl/run_detect_ctrl.sv
// Detects runs of N equal serial bits (zeros -> S2, ones -> S4), N loadable at runtime.
// Optional saturating detection counter det_cnt under macro RUN_DETECT_COUNT_EN.
module run_detect_ctrl #(
   parameter int N_W   = 4,
   parameter int N_RST = 4
) (
   input  logic         clk,
   input  logic         resetn,
   run_detect_if.slave  bus
);
   localparam logic [2:0] S0 = 3'b000;
   localparam logic [2:0] S1 = 3'b001;
   localparam logic [2:0] S2 = 3'b010;
   localparam logic [2:0] S3 = 3'b011;
   localparam logic [2:0] S4 = 3'b100;
   localparam logic [N_W-1:0] N_ONE  = {{(N_W-1){1'b0}}, 1'b1};
   localparam logic [N_W-1:0] N_INIT = N_W'(N_RST);

   logic [2:0]     st_q, st_nx;
   logic [N_W-1:0] rl_q, rl_nx, n_q, n_nx, rl_inc;
   logic           cur_bit, in_run;
`ifdef RUN_DETECT_COUNT_EN
   logic [7:0]     cnt_q, cnt_nx;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q <= S0;
         rl_q <= '0;
         n_q  <= N_INIT;
`ifdef RUN_DETECT_COUNT_EN
         cnt_q <= '0;
`endif
      end else begin
         st_q <= st_nx;
         rl_q <= rl_nx;
         n_q  <= n_nx;
`ifdef RUN_DETECT_COUNT_EN
         cnt_q <= cnt_nx;
`endif
      end
   end

   // rl < N whenever in S1/S3, so rl+1 can never wrap.
   assign rl_inc  = rl_q + N_ONE;
   assign cur_bit = (st_q == S3) || (st_q == S4);
   assign in_run  = (st_q != S0);

   always_comb begin
      st_nx = st_q;
      rl_nx = rl_q;
      n_nx  = n_q;
      if (bus.n_load) begin
         st_nx = S0;
         rl_nx = '0;
         n_nx  = (bus.n_in == '0) ? N_ONE : bus.n_in;
      end else if (st_q > S4) begin
         st_nx = S0;
         rl_nx = '0;
      end else if (bus.en) begin
         if (in_run && (bus.w == cur_bit)) begin
            // Same bit extends the run; once at N it simply holds.
            if (rl_q >= n_q) begin
               rl_nx = n_q;
            end else begin
               rl_nx = rl_inc;
               if (rl_inc == n_q) st_nx = cur_bit ? S4 : S2;
               else               st_nx = cur_bit ? S3 : S1;
            end
         end else begin
            rl_nx = N_ONE;
            if (n_q == N_ONE) st_nx = bus.w ? S4 : S2;
            else              st_nx = bus.w ? S3 : S1;
         end
      end
`ifdef RUN_DETECT_COUNT_EN
      cnt_nx = cnt_q;
      if (bus.n_load)
         cnt_nx = '0;
      else if (((st_nx == S2) || (st_nx == S4)) && (st_nx != st_q) && (cnt_q != 8'hFF))
         cnt_nx = cnt_q + 8'd1;
`endif
   end

   always_comb begin
      bus.state = st_q;
      bus.rl    = rl_q;
      bus.z     = (st_q == S2) || (st_q == S4);
`ifdef RUN_DETECT_COUNT_EN
      bus.det_cnt = cnt_q;
`endif
   end
endmodule

// File: doc/run_detect_ctrl.md
RUN_DETECT_CTRL -- requirements
Module: run_detect_ctrl

Interface
REQ-001 The block SHALL have a parameter N_W, default 4, giving the width of the run-length threshold and counter.
REQ-002 The block SHALL have a parameter N_RST, default 4, giving the threshold loaded at reset; it SHALL be in the range 1..2^N_W-1.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  sample enable; w is consumed only on cycles with en=1.
REQ-006 w  input  1  serial data bit under test.
REQ-007 n_load  input  1  threshold load strobe; also restarts detection.
REQ-008 n_in  input  N_W  new threshold value, captured when n_load=1.
REQ-009 state  output  3  current FSM state (encoding per REQ-012).
REQ-010 rl  output  N_W  current run length, saturating at N.
REQ-011 z  output  1  detect flag: 1 in S2 or S4.

Function
REQ-012 The FSM SHALL use this encoding: S0=000 start; S1=001 counting zeros; S2=010 n zeros counted; S3=011 counting ones; S4=100 n ones counted.
REQ-013 Internal threshold N: n_load=1 SHALL set N to n_in, with n_in=0 clamped to 1.
REQ-014 n_load=1 SHALL force state to S0 and rl to 0 on the same edge; it SHALL take priority over en.
REQ-015 en=0 with n_load=0 SHALL hold state, rl and N.
REQ-016 With en=1, the "run-start" rule for bit b SHALL be: set rl to 1; go to S2 (b=0) or S4 (b=1) if N=1, else to S1 (b=0) or S3 (b=1).
REQ-017 S0, any w: the block SHALL apply run-start for w.
REQ-018 S1, w=0: rl SHALL become rl+1; the next state SHALL be S2 if rl+1=N, else S1.
REQ-019 S1, w=1: the block SHALL apply run-start for 1.
REQ-020 S2, w=0: the block SHALL stay in S2 with rl held at N.
REQ-021 S2, w=1: the block SHALL apply run-start for 1.
REQ-022 S3 and S4 SHALL mirror REQ-018..021 with 0 and 1 swapped and S2 replaced by S4.
REQ-023 The unused encodings 101..111 SHALL go to S0 with rl=0 on the next edge, regardless of en.
REQ-024 z SHALL be decoded from registered state only: it is valid one cycle after the Nth equal bit is sampled and carries no combinational path from w.
REQ-025 rl arithmetic SHALL never wrap; rl SHALL never exceed N.

Reset
REQ-026 When resetn=0, the block SHALL immediately set state=S0, rl=0, N=N_RST, z=0, and det_cnt=0 when present.
REQ-027 The block SHALL be able to assert reset mid-run; after release, detection SHALL restart from S0 and the first en cycle SHALL apply REQ-017.

Configuration
REQ-028 Macro RUN_DETECT_COUNT_EN: when defined, the block SHALL add output det_cnt (8 bits), which increments by 1 on every edge where the next state is S2 or S4 and the current state is neither the same state nor reached by a hold. Entries S2->S4 and S4->S2 via run-start with N=1 count; REQ-020 holds do not.
REQ-029 det_cnt SHALL saturate at 255 and SHALL be cleared by n_load or reset.
REQ-030 Without RUN_DETECT_COUNT_EN, the det_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then en=1 with w=0,0,0,0 (N=4): state SHALL go 001,001,001,010; z SHALL be 1 after the 4th edge; rl SHALL be 4.
REQ-032 n_load with n_in=3, then w=1,1,0,1,1,1: the state sequence SHALL be 011,011,001,011,011,100; z SHALL rise only after the last edge.
REQ-033 n_in=0 load, then w=0,1,1: state SHALL go 010,100,100; z SHALL stay 1; det_cnt SHALL be 2 when RUN_DETECT_COUNT_EN is defined.
REQ-034 N=4 with w=1,1: en SHALL be dropped for 5 cycles, then w=1,1 applied; state SHALL hold 011 with rl=2 throughout the gap, then reach 100 with rl=4.
REQ-035 In S3 with rl=2, n_load=1 and en=1 with w=1 on the same edge: result SHALL be S0, rl=0, N=n_in.
REQ-036 resetn pulsed low mid-cycle while in S4: state=000 and z=0 SHALL follow immediately without waiting for a clock edge; then w=0 with N=4 SHALL go to 001.
